// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and segment tables for the sum display driver
package disp_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } disp_state_e;

    localparam int N_DIGITS = 4;
    localparam int BIN_W    = 5;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low gfedcba patterns; element [d] lights digit d.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - BCD digit to active-low 7-segment pattern
module seg7_decoder
    import disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg_n
);

    // Codes above 9 cannot come out of the converter; they fall back to blank.
    always_comb begin
        seg_n = SEG_BLANK;
        if (!blank && (digit <= 4'd9)) begin
            seg_n = SEG_TABLE[digit];
        end
    end

endmodule

// File: rtl/sum_display_driver.sv
// rtl/sum_display_driver.sv - adder result to BCD and multiplexed 7-segment scan
module sum_display_driver
    import disp_pkg::*;
#(
    parameter int  REFRESH_DIV    = 100000,
    parameter bit  SEG_ACTIVE_LOW = 1'b1,
    parameter bit  AN_ACTIVE_LOW  = 1'b1,
    localparam int CNT_W          = $clog2(REFRESH_DIV)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sum_valid,
    output logic                sum_ready,
    input  logic [3:0]          sum,
    input  logic                carry,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [N_DIGITS-1:0] an,
    output logic                conv_done
);

    disp_state_e state, state_nxt;

    logic [12:0]                   shreg, shreg_nxt;
    logic [2:0]                    step;
    logic                          pend_carry;
    logic [3:0]                    disp_tens, disp_units;
    logic                          disp_carry;
    logic [CNT_W-1:0]              refresh_cnt;
    logic [$clog2(N_DIGITS)-1:0]   digit_idx;
    logic [3:0]                    cur_digit;
    logic                          cur_blank, cur_dp;
    logic [6:0]                    seg_n;
    logic [N_DIGITS-1:0]           an_onehot;
    logic                          take, last_step;

    assign take      = sum_valid && sum_ready;
    assign last_step = (state == CONVERT) && (step == 3'(BIN_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sum_valid) state_nxt = CONVERT;
            CONVERT: if (last_step) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sum_ready = (state == IDLE);
    end

    // One double-dabble step: correct each BCD nibble, then shift.
    always_comb begin
        logic [12:0] adj;
        adj = shreg;
        if (adj[8:5]  >= 4'd5) adj[8:5]  = adj[8:5]  + 4'd3;
        if (adj[12:9] >= 4'd5) adj[12:9] = adj[12:9] + 4'd3;
        shreg_nxt = {adj[11:0], 1'b0};
    end

    // Display registers only change on the final step so a scan never sees partial digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            step       <= '0;
            pend_carry <= 1'b0;
            disp_tens  <= '0;
            disp_units <= '0;
            disp_carry <= 1'b0;
            conv_done  <= 1'b0;
        end else begin
            conv_done <= 1'b0;
            if (take) begin
                shreg      <= {8'd0, carry, sum};
                step       <= '0;
                pend_carry <= carry;
            end else if (state == CONVERT) begin
                shreg <= shreg_nxt;
                step  <= step + 3'd1;
                if (last_step) begin
                    disp_tens  <= shreg_nxt[12:9];
                    disp_units <= shreg_nxt[8:5];
                    disp_carry <= pend_carry;
                    conv_done  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Slot 1 blanks a leading zero; slots 2 and 3 are always dark but still scanned.
    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b1;
        cur_dp    = 1'b0;
        case (digit_idx)
            2'd0: begin
                cur_digit = disp_units;
                cur_blank = 1'b0;
                cur_dp    = disp_carry;
            end
            2'd1: begin
                cur_digit = disp_tens;
                cur_blank = (disp_tens == 4'd0);
            end
            default: ;
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .digit (cur_digit),
        .blank (cur_blank),
        .seg_n (seg_n)
    );

    assign an_onehot = N_DIGITS'(1) << digit_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= {7{SEG_ACTIVE_LOW}};
            dp  <= SEG_ACTIVE_LOW;
            an  <= {N_DIGITS{AN_ACTIVE_LOW}};
        end else begin
            seg <= SEG_ACTIVE_LOW ? seg_n   : ~seg_n;
            dp  <= SEG_ACTIVE_LOW ? ~cur_dp : cur_dp;
            an  <= AN_ACTIVE_LOW  ? ~an_onehot : an_onehot;
        end
    end

endmodule

// File: tb/tb_sum_display_driver.sv
// tb/tb_sum_display_driver.sv - randomized self-checking bench for sum_display_driver
module tb_sum_display_driver;

    localparam int REFRESH_DIV = 4;
    localparam logic [6:0] TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sum_valid;
    logic       sum_ready;
    logic [3:0] sum;
    logic       carry;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       conv_done;

    int n_checks = 0;
    int n_err    = 0;

    sum_display_driver #(
        .REFRESH_DIV    (REFRESH_DIV),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .sum       (sum),
        .carry     (carry),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .conv_done (conv_done)
    );

    always #5 clk = ~clk;

    // Reference model: shown value, pending capture countdown, and scan slot derived from elapsed cycles.
    int m_t, m_disp, m_cap, m_cd, m_slot, m_val;
    bit m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t    <= 0;
            m_disp <= 0;
            m_cap  <= 0;
            m_cd   <= 0;
            m_slot <= -1;
            m_val  <= 0;
            m_done <= 1'b0;
        end else begin
            m_slot <= (m_t / REFRESH_DIV) % 4;
            m_val  <= m_disp;
            m_t    <= m_t + 1;
            m_done <= (m_cd == 1);
            if (m_cd > 0) begin
                m_cd <= m_cd - 1;
                if (m_cd == 1) m_disp <= m_cap;
            end else if (sum_valid) begin
                m_cap <= {carry, sum};
                m_cd  <= 5;
            end
        end
    end

    function automatic logic [13:0] exp_vec();
        logic [6:0] s;
        logic       d;
        logic [3:0] a;
        if (m_slot < 0) begin
            s = 7'h7F; d = 1'b1; a = 4'hF;
        end else begin
            a = ~(4'b0001 << m_slot);
            d = !(m_slot == 0 && m_val >= 16);
            case (m_slot)
                0:       s = TBL[m_val % 10];
                1:       s = (m_val / 10 == 0) ? 7'h7F : TBL[m_val / 10];
                default: s = 7'h7F;
            endcase
        end
        return {s, d, a, (m_cd == 0), m_done};
    endfunction

    task automatic send(input logic [4:0] v);
        sum       = v[3:0];
        carry     = v[4];
        sum_valid = 1'b1;
        @(posedge clk);
        #1;
        sum_valid = 1'b0;
        sum       = 4'($urandom);
        carry     = 1'($urandom);
    endtask

    task automatic test_reset();
        logic [3:0] an_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        rst_n = 1'b0; sum_valid = 1'b0; sum = 4'h0; carry = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({seg, dp, an, sum_ready, conv_done} !== {7'h7F, 1'b1, 4'hF, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state got=%h exp=%h", {seg, dp, an, sum_ready, conv_done},
                     {7'h7F, 1'b1, 4'hF, 1'b1, 1'b0});
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            n_checks++;
            if ({seg, dp, an, sum_ready, conv_done} !== exp_vec()) begin
                n_err++;
                $display("FAIL idle_cycle k=%0d got=%h exp=%h", k, {seg, dp, an, sum_ready, conv_done}, exp_vec());
            end
            if (k % 4 == 1) begin
                n_checks++;
                if (an !== an_seq[(k-1)/4] || seg !== ((k == 1) ? 7'h40 : 7'h7F) || dp !== 1'b1) begin
                    n_err++;
                    $display("FAIL idle_scan k=%0d an=%h seg=%h dp=%b exp_an=%h", k, an, seg, dp, an_seq[(k-1)/4]);
                end
            end
        end
    endtask

    task automatic test_convert(input logic [4:0] v, input logic [6:0] u_seg,
                                input logic [6:0] t_seg, input logic dp_exp);
        int ready_low = 0;
        int done_at   = -1;
        send(v);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            n_checks++;
            if ({seg, dp, an, sum_ready, conv_done} !== exp_vec()) begin
                n_err++;
                $display("FAIL convert_cycle v=%0d k=%0d got=%h exp=%h", v, k, {seg, dp, an, sum_ready, conv_done}, exp_vec());
            end
            if (!sum_ready) ready_low++;
            if (conv_done && done_at < 0) done_at = k;
            if (k > 6 && an == 4'hE) begin
                n_checks++;
                if (seg !== u_seg || dp !== dp_exp) begin
                    n_err++;
                    $display("FAIL units_digit v=%0d seg=%h dp=%b exp_seg=%h exp_dp=%b", v, seg, dp, u_seg, dp_exp);
                end
            end
            if (k > 6 && an == 4'hD) begin
                n_checks++;
                if (seg !== t_seg) begin
                    n_err++;
                    $display("FAIL tens_digit v=%0d seg=%h exp=%h", v, seg, t_seg);
                end
            end
        end
        n_checks++;
        if (ready_low != 5 || done_at != 6) begin
            n_err++;
            $display("FAIL latency v=%0d ready_low=%0d done_at=%0d exp=5/6", v, ready_low, done_at);
        end
    endtask

    task automatic test_ignore_busy();
        send(5'd5);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            n_checks++;
            if ({seg, dp, an, sum_ready, conv_done} !== exp_vec()) begin
                n_err++;
                $display("FAIL busy_cycle k=%0d got=%h exp=%h", k, {seg, dp, an, sum_ready, conv_done}, exp_vec());
            end
            if (k > 6 && an == 4'hE) begin
                n_checks++;
                if (seg !== 7'h12) begin
                    n_err++;
                    $display("FAIL busy_ignored seg=%h exp=%h", seg, 7'h12);
                end
            end
            if (k == 2) begin sum_valid = 1'b1; sum = 4'h3; carry = 1'b0; end
            if (k == 4) sum_valid = 1'b0;
        end
        test_convert(5'd3, 7'h30, 7'h7F, 1'b1);
    endtask

    task automatic test_reset_mid();
        test_convert(5'd12, 7'h24, 7'h79, 1'b1);
        send(5'h1F);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({seg, dp, an, sum_ready, conv_done} !== {7'h7F, 1'b1, 4'hF, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset got=%h exp=%h", {seg, dp, an, sum_ready, conv_done},
                     {7'h7F, 1'b1, 4'hF, 1'b1, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            n_checks++;
            if ({seg, dp, an, sum_ready, conv_done} !== exp_vec()) begin
                n_err++;
                $display("FAIL after_reset k=%0d got=%h exp=%h", k, {seg, dp, an, sum_ready, conv_done}, exp_vec());
            end
            n_checks++;
            if (conv_done !== 1'b0 || sum_ready !== 1'b1 || (an == 4'hE && (seg !== 7'h40 || dp !== 1'b1))) begin
                n_err++;
                $display("FAIL aborted_conv k=%0d conv_done=%b sum_ready=%b seg=%h exp=0/1/40", k, conv_done, sum_ready, seg);
            end
        end
    endtask

    task automatic test_sweep();
        int order [32];
        for (int i = 0; i < 32; i++) order[i] = i;
        for (int i = 31; i > 0; i--) begin
            int j, tmp;
            j = $urandom_range(i, 0);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 32; i++) begin
            int gap;
            gap = $urandom_range(3, 0);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                n_checks++;
                if ({seg, dp, an, sum_ready, conv_done} !== exp_vec()) begin
                    n_err++;
                    $display("FAIL sweep_gap got=%h exp=%h", {seg, dp, an, sum_ready, conv_done}, exp_vec());
                end
            end
            send(5'(order[i]));
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                n_checks++;
                if ({seg, dp, an, sum_ready, conv_done} !== exp_vec()) begin
                    n_err++;
                    $display("FAIL sweep_cycle v=%0d k=%0d got=%h exp=%h", order[i], k,
                             {seg, dp, an, sum_ready, conv_done}, exp_vec());
                end
                if (k >= 2 && k <= 3) begin
                    sum_valid = 1'($urandom);
                    sum       = 4'($urandom);
                    carry     = 1'($urandom);
                end
                if (k == 4) sum_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_convert(5'h1F, 7'h79, 7'h30, 1'b0);
        test_convert(5'h09, 7'h10, 7'h7F, 1'b1);
        test_convert(5'h0A, 7'h40, 7'h79, 1'b1);
        test_ignore_busy();
        test_reset_mid();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
